// File: rtl/dqs_rd_calib.sv
// Read-side DQS delay trainer: sweeps the DQS input-delay tap, finds the first contiguous
// passing window against the expected ISERDES toggle pattern and parks the delay at its centre.
module dqs_rd_calib #(
  parameter int unsigned DLY_BITS      = 5,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_COUNT  = 16,
  parameter logic [3:0]  EXP_PATTERN   = 4'b0101,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dly_ready,
  input  logic [3:0]          dqs_samples,
  input  logic                dqs_valid,
  output logic [DLY_BITS-1:0] dly_data,
  output logic                ld,
  output logic                set,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [DLY_BITS-1:0] win_first,
  output logic [DLY_BITS-1:0] win_last
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SMP_W = $clog2(SAMPLE_COUNT + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [DLY_BITS-1:0] TAP_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, LOAD, SET, SETTLE, SAMPLE, EVAL, CLD, CSET, DONE
  } state_t;

  state_t              state, state_nxt;
  logic [DLY_BITS-1:0] tap, tap_nxt;
  logic [SET_W-1:0]    settle_cnt, settle_nxt;
  logic [SMP_W-1:0]    match_cnt, match_nxt;
  logic [TO_W-1:0]     idle_cnt, idle_nxt;
  logic                win_open, win_open_nxt;
  logic                tap_pass, tap_pass_nxt;
  logic [DLY_BITS-1:0] dly_data_nxt, win_first_nxt, win_last_nxt;
  logic                ld_nxt, set_nxt, busy_nxt, done_nxt, fail_nxt;
  logic [DLY_BITS:0]   centre_sum;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tap        <= '0;
      settle_cnt <= '0;
      match_cnt  <= '0;
      idle_cnt   <= '0;
      win_open   <= 1'b0;
      tap_pass   <= 1'b0;
      dly_data   <= '0;
      ld         <= 1'b0;
      set        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      win_first  <= '0;
      win_last   <= '0;
    end else begin
      state      <= state_nxt;
      tap        <= tap_nxt;
      settle_cnt <= settle_nxt;
      match_cnt  <= match_nxt;
      idle_cnt   <= idle_nxt;
      win_open   <= win_open_nxt;
      tap_pass   <= tap_pass_nxt;
      dly_data   <= dly_data_nxt;
      ld         <= ld_nxt;
      set        <= set_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      fail       <= fail_nxt;
      win_first  <= win_first_nxt;
      win_last   <= win_last_nxt;
    end
  end

  // Next-state and next-output logic; ld/set are raised on entry so they cover exactly one state
  always_comb begin
    state_nxt     = state;
    tap_nxt       = tap;
    settle_nxt    = settle_cnt;
    match_nxt     = match_cnt;
    idle_nxt      = idle_cnt;
    win_open_nxt  = win_open;
    tap_pass_nxt  = tap_pass;
    dly_data_nxt  = dly_data;
    ld_nxt        = 1'b0;
    set_nxt       = 1'b0;
    busy_nxt      = busy;
    done_nxt      = done;
    fail_nxt      = fail;
    win_first_nxt = win_first;
    win_last_nxt  = win_last;
    centre_sum    = '0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt     = WAIT_RDY;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          fail_nxt      = 1'b0;
          tap_nxt       = '0;
          win_open_nxt  = 1'b0;
          win_first_nxt = '0;
          win_last_nxt  = '0;
        end
      end
      WAIT_RDY: begin
        if (dly_ready) begin
          state_nxt    = LOAD;
          dly_data_nxt = tap;
          ld_nxt       = 1'b1;
        end
      end
      LOAD: begin
        state_nxt = SET;
        set_nxt   = 1'b1;
      end
      SET: begin
        state_nxt  = SETTLE;
        settle_nxt = '0;
      end
      SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nxt = SAMPLE;
          match_nxt = '0;
          idle_nxt  = '0;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        if (dqs_valid) begin
          idle_nxt = '0;
          if (dqs_samples != EXP_PATTERN) begin
            tap_pass_nxt = 1'b0;
            state_nxt    = EVAL;
          end else if (match_cnt == SMP_W'(SAMPLE_COUNT - 1)) begin
            tap_pass_nxt = 1'b1;
            state_nxt    = EVAL;
          end else begin
            match_nxt = match_cnt + 1'b1;
          end
        end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
          // No read traffic: abort and park the delay at tap 0
          fail_nxt     = 1'b1;
          tap_nxt      = '0;
          state_nxt    = CLD;
          ld_nxt       = 1'b1;
          dly_data_nxt = '0;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      EVAL: begin
        if (tap_pass) begin
          win_last_nxt = tap;
          if (!win_open) begin
            win_first_nxt = tap;
            win_open_nxt  = 1'b1;
          end
        end
        if ((!tap_pass && win_open) || (tap == TAP_MAX)) begin
          state_nxt = CLD;
          ld_nxt    = 1'b1;
          if (win_open_nxt) begin
            centre_sum   = {1'b0, win_first_nxt} + {1'b0, win_last_nxt};
            dly_data_nxt = centre_sum[DLY_BITS:1];
          end else begin
            dly_data_nxt = '0;
            fail_nxt     = 1'b1;
          end
        end else begin
          tap_nxt      = tap + 1'b1;
          dly_data_nxt = tap + 1'b1;
          state_nxt    = LOAD;
          ld_nxt       = 1'b1;
        end
      end
      CLD: begin
        state_nxt = CSET;
        set_nxt   = 1'b1;
      end
      CSET: begin
        state_nxt = DONE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
